// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame sequencer.
package pixel_pkg;

  localparam int PX_BITS = 8;
  localparam logic [PX_BITS-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ERASE    = 3'd1,
    ST_EXPOSE   = 3'd2,
    ST_CONVERT  = 3'd3,
    ST_TURN     = 3'd4,
    ST_READ_SEL = 3'd5,
    ST_READ_OUT = 3'd6
  } frame_state_t;

endpackage

// File: rtl/pixel_phase_timer.sv
// Loadable down-counter; o_done flags a zero count, o_count_nxt is the value
// the counter takes at the next edge (so callers can register derived outputs).
module pixel_phase_timer
  import pixel_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [PX_BITS-1:0] i_load_val,
  output logic [PX_BITS-1:0] o_count_nxt,
  output logic               o_done
);

  logic [PX_BITS-1:0] r_count;
  logic [PX_BITS-1:0] w_count_nxt;

  // Saturates at zero so an idle timer keeps reporting done.
  always_comb begin
    w_count_nxt = r_count;
    if (i_load) begin
      w_count_nxt = i_load_val;
    end else if (r_count != '0) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count_nxt = w_count_nxt;
  assign o_done      = (r_count == '0);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Start-triggered frame sequencer: erase/expose/convert phases, then per-row
// sampling of the column buses handed out over a valid/ready port.
module pixel_frame_ctrl
  import pixel_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int COLS       = 4,
  parameter int ERASE_CYC  = 5,
  parameter int EXPOSE_CYC = 255,
  parameter int SETTLE_CYC = 2,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      erase,
  output logic                      expose,
  output logic                      convert,
  output logic                      read,
  output logic [ROWS-1:0]           row_sel,
  output logic                      data_oe,
  output logic [PX_BITS*COLS-1:0]   data_out,
  input  logic [PX_BITS*COLS-1:0]   data_in,
  output logic                      px_valid,
  input  logic                      px_ready,
  output logic [PX_BITS*COLS-1:0]   px_data,
  output logic [RW-1:0]             px_row,
  output logic                      busy,
  output logic                      frame_done,
  output frame_state_t              state_dbg
);

  frame_state_t             r_state, w_state_nxt;
  logic [RW-1:0]            r_row, w_row_nxt;
  logic                     w_load, w_capture, w_last_hs, w_tmr_done;
  logic [PX_BITS-1:0]       w_load_val, w_count_nxt, w_conv;
  logic                     r_erase, r_expose, r_convert, r_read, r_data_oe;
  logic                     r_px_valid, r_busy, r_frame_done;
  logic [ROWS-1:0]          r_row_sel;
  logic [PX_BITS*COLS-1:0]  r_data_out, r_px_data;
  logic [RW-1:0]            r_px_row;

  pixel_phase_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .o_count_nxt (w_count_nxt),
    .o_done      (w_tmr_done)
  );

  // Handshake: a sample transfers on a rising edge where px_valid and
  // px_ready are both 1; px_data/px_row hold until then, px_ready is ignored
  // whenever px_valid is 0.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_capture   = 1'b0;
    w_last_hs   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_ERASE;
        w_row_nxt   = '0;
        w_load      = 1'b1;
        w_load_val  = PX_BITS'(ERASE_CYC - 1);
      end
      ST_ERASE: if (w_tmr_done) begin
        w_state_nxt = ST_EXPOSE;
        w_load      = 1'b1;
        w_load_val  = PX_BITS'(EXPOSE_CYC - 1);
      end
      ST_EXPOSE: if (w_tmr_done) begin
        w_state_nxt = ST_CONVERT;
        w_load      = 1'b1;
        w_load_val  = CNT_MAX;
      end
      ST_CONVERT: if (w_tmr_done) w_state_nxt = ST_TURN;
      ST_TURN: begin
        w_state_nxt = ST_READ_SEL;
        w_load      = 1'b1;
        w_load_val  = PX_BITS'(SETTLE_CYC - 1);
      end
      ST_READ_SEL: if (w_tmr_done) begin
        w_state_nxt = ST_READ_OUT;
        w_capture   = 1'b1;
      end
      ST_READ_OUT: if (px_ready) begin
        if (r_row == RW'(ROWS - 1)) begin
          w_state_nxt = ST_IDLE;
          w_last_hs   = 1'b1;
        end else begin
          w_state_nxt = ST_READ_SEL;
          w_row_nxt   = r_row + RW'(1);
          w_load      = 1'b1;
          w_load_val  = PX_BITS'(SETTLE_CYC - 1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The timer counts 255..0 through CONVERT, so the broadcast ramp is its complement.
  assign w_conv = CNT_MAX - w_count_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_erase      <= 1'b0;
      r_expose     <= 1'b0;
      r_convert    <= 1'b0;
      r_read       <= 1'b0;
      r_row_sel    <= '0;
      r_data_oe    <= 1'b0;
      r_data_out   <= '0;
      r_px_valid   <= 1'b0;
      r_px_data    <= '0;
      r_px_row     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_erase      <= (w_state_nxt == ST_ERASE);
      r_expose     <= (w_state_nxt == ST_EXPOSE);
      r_convert    <= (w_state_nxt == ST_CONVERT);
      r_read       <= (w_state_nxt == ST_TURN) || (w_state_nxt == ST_READ_SEL) ||
                      (w_state_nxt == ST_READ_OUT);
      r_row_sel    <= ((w_state_nxt == ST_READ_SEL) || (w_state_nxt == ST_READ_OUT)) ?
                      (ROWS'(1) << w_row_nxt) : '0;
      r_data_oe    <= (w_state_nxt == ST_CONVERT);
      r_data_out   <= (w_state_nxt == ST_CONVERT) ? {COLS{w_conv}} : '0;
      r_px_valid   <= (w_state_nxt == ST_READ_OUT);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= w_last_hs;
      if (w_capture) begin
        r_px_data <= data_in;
        r_px_row  <= r_row;
      end
    end
  end

  assign erase      = r_erase;
  assign expose     = r_expose;
  assign convert    = r_convert;
  assign read       = r_read;
  assign row_sel    = r_row_sel;
  assign data_oe    = r_data_oe;
  assign data_out   = r_data_out;
  assign px_valid   = r_px_valid;
  assign px_data    = r_px_data;
  assign px_row     = r_px_row;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign state_dbg  = r_state;

endmodule
